// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared constants and types for the multiplexed seven-segment driver.
// Glyphs are listed in segment order a..g with a lit segment as 1; the
// drivers invert them for the common-anode, active-low segment pins.
package sevseg_pkg;

    // All segments dark on an active-low segment bus.
    localparam logic [0:6] SEG_OFF = 7'b1111111;

    // Hex glyphs 0..F, index = nibble value, bit [0] of each entry is segment a.
    localparam logic [0:6] HEX_GLYPH [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1110011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    // Scan FSM: a digit is lit in SHOW, then one dark GAP cycle follows.
    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sevseg_scan_driver_hex7_decode.sv
// hex7_decode: combinational nibble to active-low segment lookup.
module hex7_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    assign seg = ~HEX_GLYPH[nibble];

endmodule

// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: time-multiplexed N-digit hex display driver.
// Latches VALUE/BLANK on LOAD, scans one digit at a time with a one-cycle
// dark gap between digits, and registers the segment and anode outputs.
// Optional build macro: SEVSEG_LZ_SUPPRESS_EN enables leading-zero blanking.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic [NUM_DIGITS-1:0]   BLANK,
    output logic [0:6]              SEV,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [PRE_W-1:0]        presc;
    logic [IDX_W-1:0]        idx;
    scan_state_t             state;

    logic [3:0]              cur_nibble;
    logic [0:6]              cur_seg;
    logic                    digit_dark;
    logic [NUM_DIGITS-1:0]   an_sel;

    // Shadow registers: the display only ever reads these, never VALUE directly.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val_q   <= '0;
            blank_q <= '0;
        end else if (LOAD) begin
            val_q   <= VALUE;
            blank_q <= BLANK;
        end
    end

`ifdef SEVSEG_LZ_SUPPRESS_EN
    logic seen_nonzero;

    // Flag every digit above the most significant nonzero nibble; digit 0 is never flagged.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        seen_nonzero = 1'b0;
        lz_mask      = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (val_q[4*k +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            lz_mask[k] = ~seen_nonzero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign cur_nibble = val_q[4*int'(idx) +: 4];
    assign digit_dark = blank_q[idx] | lz_mask[idx];
    assign an_sel     = ~(NUM_DIGITS'(1) << idx);

    hex7_decode u_hex7_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Scan FSM with prescaler, digit index and registered SEV/AN outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= SHOW;
            presc <= '0;
            idx   <= '0;
            SEV   <= SEG_OFF;
            AN    <= '1;
        end else begin
            case (state)
                SHOW: begin
                    AN  <= an_sel;
                    SEV <= digit_dark ? SEG_OFF : cur_seg;
                    if (presc == PRE_LAST) begin
                        state <= GAP;
                        presc <= '0;
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end
                GAP: begin
                    AN    <= '1;
                    SEV   <= SEG_OFF;
                    state <= SHOW;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
                default: begin
                    state <= SHOW;
                    AN    <= '1;
                    SEV   <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Multiplexed N-digit hexadecimal seven-segment display driver, the parametrised successor to the single-digit hex-to-segment decoder. It latches a packed multi-nibble value on a load strobe and time-multiplexes it across `NUM_DIGITS` common-anode digits, each with its own digit enable. Scanning uses an internal prescaler with a dead-time gap between digits, and digits can be blanked individually. It sits between the calculator datapath result register and the board display pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit; legal minimum 1.
- `CLK` input 1: single system clock; all state changes on its rising edge.
- `RST` input 1: reset, asynchronous and active-high.
- `LOAD` input 1: capture strobe; when high on a `CLK` edge, `VALUE` and `BLANK` are latched.
- `VALUE` input 4*NUM_DIGITS: packed nibbles; digit k is `VALUE[4k+3:4k]`, and digit 0 is the rightmost.
- `BLANK` input NUM_DIGITS: per-digit blank mask; a 1 forces that digit dark.
- `SEV` output [0:6]: segments a..g, where `SEV[0]`=a; active-low; registered.
- `AN` output NUM_DIGITS: digit enables, active-low, one-hot-low or all-high; registered.

## Operation
- Shadow registers `val_q` and `blank_q` load on `LOAD`. The display always reads from the shadow registers, never directly from `VALUE`.
- Hex glyphs, with a b c d e f g active-high before inversion:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- `SEV` is the bitwise inverse of the glyph. A blanked digit drives `SEV`=7'b1111111.
- FSM, two states:
  - SHOW: `AN` drives the current index `idx` low. The prescaler counts 0..REFRESH_DIV-1. At terminal count it goes to GAP and the prescaler clears.
  - GAP: exactly one cycle with `AN` all-high and `SEV` all-high (anti-ghosting). Then `idx` advances and the FSM returns to SHOW.
- `idx` advances by 1 and wraps from NUM_DIGITS-1 to 0. When NUM_DIGITS=1, `idx` stays 0 and GAP still occurs.
- LOAD during SHOW: the lit digit's `SEV` reflects the new value on the cycle after the load edge. Scan position and prescaler are unaffected.
- LOAD during GAP: captured normally; visible when the next digit is lit.
- LOAD held high: the shadow registers track `VALUE` every cycle.

## Timing
- Reset values (asynchronous, immediate on `RST` rising):
  - `SEV`=7'b1111111, `AN`=all ones
  - `idx`=0, prescaler=0, state=SHOW
  - `val_q`=0, `blank_q`=0
- First lit output: the first `CLK` edge after `RST` falls drives `AN[0]` low with the glyph of `val_q` digit 0, which is "0".
- Output latency: one cycle from the state/shadow register to `SEV`/`AN`.
- Per-digit period: REFRESH_DIV lit cycles plus 1 gap cycle. Full frame: NUM_DIGITS*(REFRESH_DIV+1) cycles.
- `RST` asserted mid-scan or mid-GAP: all outputs go dark immediately; the scan restarts at digit 0.
- `AN` never has more than one bit low in any cycle.

## Configuration
- `SEVSEG_LZ_SUPPRESS_EN` defined: leading-zero suppression.
  - Every digit above the most significant nonzero nibble of `val_q` is treated as blanked, in addition to `blank_q`.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - Suppression is computed from `val_q` and takes effect with the same latency as LOAD.
- Not defined: only `blank_q` blanks digits, and leading zeros are displayed.

## Structure
- Package `sevseg_pkg` holds:
  - the 16-entry glyph constant array
  - `SEG_OFF`=7'b1111111
  - the FSM state enum `scan_state_t` {SHOW, GAP}
- Sub-module `hex7_decode`: combinational nibble-to-active-low-segment lookup using the package array, instantiated once on the muxed nibble.
- The top level holds the shadow registers, prescaler, `idx`, FSM, LZ logic, and output registers.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- **Reset and first digit:** assert `RST` -> `SEV`=7'h7F and `AN`=4'b1111. Release `RST` -> next edge gives `AN`=4'b1110 and `SEV`=7'b0000001, then 4 lit cycles.
- **Scan order and gap:** LOAD `VALUE`=16'h1A2F -> per-digit sequence is
  - `AN` 1110 with F (0111000)
  - 1 gap cycle with 1111
  - 1101 with 2 (0010010)
  - 1011 with A (0001000)
  - 0111 with 1 (1001111)
  - wrap to 1110, with 5-cycle digit periods.
- **Blanking:** `BLANK`=4'b0100 with `VALUE`=16'h8888 -> while `AN`=1011, `SEV`=7'h7F; other digits show 8 (0000000).
- **Mid-scan load:** LOAD 16'h0003 then 16'h0005 while digit 0 is lit -> `SEV` changes from 0000110 to 0100100 one cycle after the second LOAD; the prescaler is not reset.
- **LZ suppression (`SEVSEG_LZ_SUPPRESS_EN` defined):**
  - `VALUE`=16'h0040 -> digits 3 and 2 dark; digit 1 shows 4; digit 0 shows 0.
  - `VALUE`=0 -> only digit 0 shows "0".
- **Asynchronous reset mid-operation:** assert `RST` in the middle of a digit's lit window -> outputs dark before the next `CLK` edge. After release, the scan restarts at `AN`=1110 with `val_q`=0.
